sub_result_display: RTL and testbench
=====================================

SUB_RESULT_DISPLAY -- requirements
Module: sub_result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each display digit stays selected (legal >= 2).
REQ-002 Parameter MIN_HOLD, default 25000000, minimum cycles a captured result is held before the next capture (legal >= 0).
REQ-003 Port clk  input  1  single system clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port result  input  2  subtraction result, two's complement when sign = 0.
REQ-006 Port sign  input  1  1 = non-negative, 0 = negative.
REQ-007 Port in_valid  input  1  result/sign valid this cycle.
REQ-008 Port in_ready  output  1  block accepts a new result this cycle.
REQ-009 Port disp_valid  output  1  at least one result captured since reset.
REQ-010 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port an  output  2  digit anodes, active-low; an[0] right digit, an[1] left digit.

Function
REQ-012 Capture occurs on a rising edge where in_valid = 1 and in_ready = 1; result and sign are registered at that edge.
REQ-013 Stored magnitude: sign = 1 -> result; sign = 0 -> (~result + 1) mod 4.
REQ-014 Stored negative flag = (sign = 0) AND (magnitude != 0); a zero magnitude never shows a minus.
REQ-015 Hold counter: on capture at edge k, in_ready = 0 for cycles k+1 .. k+MIN_HOLD and returns to 1 at k+MIN_HOLD+1; MIN_HOLD = 0 keeps in_ready = 1 permanently.
REQ-016 in_valid while in_ready = 0 is ignored, never queued; stored value and hold counter unchanged.
REQ-017 States: EMPTY (no capture since reset) and SHOW; EMPTY -> SHOW on first capture; SHOW -> SHOW on later captures; only reset returns to EMPTY.
REQ-018 disp_valid = 1 exactly in SHOW.
REQ-019 Refresh counter counts 0 .. REFRESH_DIV-1 and wraps to 0; digit select toggles on the wrap edge.
REQ-020 an = 2'b10 while the right digit is selected and 2'b01 while the left digit is selected; never 2'b00.
REQ-021 Right digit pattern: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30.
REQ-022 Left digit pattern: minus (g only) = 7'h3F when the negative flag is set, else blank = 7'h7F.
REQ-023 In EMPTY both digits show 7'h7F.
REQ-024 seg and an are registered: they reflect digit select and stored value as of the previous edge (1-cycle latency).
REQ-025 Capture coinciding with a digit-select toggle: both take effect; the first refreshed pattern uses the new value.
REQ-026 Refresh scanning is independent of capture and hold; in_valid never stalls or resets the refresh counter.

Reset
REQ-027 While rst = 1, asynchronously: state EMPTY, refresh counter 0, right digit selected, hold counter 0, stored magnitude 0, negative flag 0.
REQ-028 Outputs during and after reset: seg = 7'h7F, an = 2'b10, in_ready = 1, disp_valid = 0.
REQ-029 Reset asserted mid-hold or mid-refresh aborts immediately; the first capture after release is accepted on any edge with in_valid = 1.

Verification (REFRESH_DIV = 4, MIN_HOLD = 3)
REQ-030 Reset, no input for 20 cycles -> seg = 7'h7F throughout, an alternates 2'b10/2'b01 every 4 cycles, disp_valid = 0, in_ready = 1.
REQ-031 Capture result = 2'b10, sign = 1 -> right digit 7'h24, left digit 7'h7F, disp_valid = 1, in_ready low for exactly 3 cycles.
REQ-032 Capture result = 2'b11, sign = 0 -> right digit 7'h79, left digit 7'h3F; capture result = 2'b00, sign = 0 -> right 7'h40, left 7'h7F.
REQ-033 Second in_valid 1 cycle after a capture with different data -> ignored, display unchanged; the same data presented again at cycle k+4 -> accepted.
REQ-034 Capture on the same edge as a digit-select wrap -> no stale pattern appears on the newly selected digit.
REQ-035 rst pulsed 2 cycles after a capture (in hold) -> seg = 7'h7F, an = 2'b10, in_ready = 1, disp_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sub_result_display_if.sv
// Result/display bundle between a subtractor front end and the two-digit display block.
interface sub_result_display_if;
    logic [1:0] result;
    logic       sign;
    logic       in_valid;
    logic       in_ready;
    logic       disp_valid;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (output result, sign, in_valid, input in_ready, disp_valid, seg, an);
    modport slave  (input result, sign, in_valid, output in_ready, disp_valid, seg, an);
endinterface

// File: rtl/sub_result_display.sv
// Captures a signed 2-bit subtraction result, holds it for MIN_HOLD cycles and
// multiplexes it onto a two-digit active-low seven-segment display (sign + magnitude).
module sub_result_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int MIN_HOLD    = 25000000
) (
    input logic                 clk,
    input logic                 rst,
    sub_result_display_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    typedef enum logic {EMPTY, SHOW} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    mag_q, mag_d;
    logic          neg_q, neg_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          cap;
    logic [1:0]    mag_in;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q + 1'b1;
        sel_d   = sel_q;
        hold_d  = hold_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        seg_d   = 7'h7F;
        an_d    = sel_q ? 2'b01 : 2'b10;

        cap    = bus.in_valid && (hold_q == '0);
        mag_in = bus.sign ? bus.result : (~bus.result + 2'd1);

        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            sel_d = ~sel_q;
        end

        if (hold_q != '0) hold_d = hold_q - 1'b1;

        if (cap) begin
            state_d = SHOW;
            hold_d  = HW'(MIN_HOLD);
            mag_d   = mag_in;
            neg_d   = !bus.sign && (mag_in != 2'd0);
        end

        // Pattern comes from the pre-edge select and stored value: one cycle of latency.
        if (state_q == SHOW) begin
            if (sel_q) begin
                seg_d = neg_q ? 7'h3F : 7'h7F;
            end else begin
                unique case (mag_q)
                    2'd0: seg_d = 7'h40;
                    2'd1: seg_d = 7'h79;
                    2'd2: seg_d = 7'h24;
                    2'd3: seg_d = 7'h30;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ref_q   <= '0;
            sel_q   <= 1'b0;
            hold_q  <= '0;
            mag_q   <= 2'd0;
            neg_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 2'b10;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.in_ready   = (hold_q == '0);
    assign bus.disp_valid = (state_q == SHOW);
    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
endmodule

// File: tb/tb_sub_result_display.sv
// Vector table + scoreboard bench: captures push expected digit patterns, a cycle model pops them.
module tb_sub_result_display;
    localparam int RDIV = 4;
    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sub_result_display_if bus ();

    sub_result_display #(.REFRESH_DIV(RDIV), .MIN_HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [1:0] res;
        logic       sg;
        logic [6:0] er;
        logic [6:0] el;
    } vec_t;

    vec_t        vec [8];
    logic [13:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        cap_exp = 1'b0;
    logic        chk_en = 1'b0;

    // cycle model of scanning, hold and stored patterns
    int          m_cnt = 0;
    int          m_hold = 0;
    logic        m_sel = 1'b0;
    logic        m_valid = 1'b0;
    logic [6:0]  m_right = 7'h7F;
    logic [6:0]  m_left = 7'h7F;
    logic [6:0]  m_seg = 7'h7F;
    logic [1:0]  m_an = 2'b10;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_sel = 1'b0; m_hold = 0; m_valid = 1'b0;
                m_right = 7'h7F; m_left = 7'h7F; m_seg = 7'h7F; m_an = 2'b10;
            end else begin
                m_an  = m_sel ? 2'b01 : 2'b10;
                m_seg = !m_valid ? 7'h7F : (m_sel ? m_left : m_right);
                if (m_cnt == RDIV - 1) begin m_cnt = 0; m_sel = !m_sel; end
                else m_cnt++;
                if (m_hold > 0) m_hold--;
                if (cap_exp) begin
                    if (sb.size() > 0) {m_right, m_left} = sb.pop_front();
                    else chk("sb_underflow", 1, 0);
                    m_valid = 1'b1;
                    m_hold  = HOLD;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                chk("seg", bus.seg, m_seg);
                chk("an", bus.an, m_an);
                chk("disp_valid", bus.disp_valid, m_valid);
                chk("in_ready", bus.in_ready, m_hold == 0);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Present vector i for one edge; capture is expected only when the model says ready.
    task automatic send(input int i);
        bus.result   = vec[i].res;
        bus.sign     = vec[i].sg;
        bus.in_valid = 1'b1;
        if (m_hold == 0) begin
            sb.push_back({vec[i].er, vec[i].el});
            cap_exp = 1'b1;
        end
        tick(1);
        bus.in_valid = 1'b0;
        cap_exp      = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (m_hold != 0 && n < 20) begin tick(1); n++; end
        if (n >= 20) chk("wait_ready_timeout", n, 0);
    endtask

    initial begin
        int n;
        vec[0] = '{2'b10, 1'b1, 7'h24, 7'h7F};
        vec[1] = '{2'b11, 1'b0, 7'h79, 7'h3F};
        vec[2] = '{2'b00, 1'b0, 7'h40, 7'h7F};
        vec[3] = '{2'b01, 1'b1, 7'h79, 7'h7F};
        vec[4] = '{2'b00, 1'b1, 7'h40, 7'h7F};
        vec[5] = '{2'b01, 1'b0, 7'h30, 7'h3F};
        vec[6] = '{2'b10, 1'b0, 7'h24, 7'h3F};
        vec[7] = '{2'b11, 1'b1, 7'h30, 7'h7F};
        bus.result = 2'b00; bus.sign = 1'b1; bus.in_valid = 1'b0;

        // asynchronous reset, observed before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_an", bus.an, 2'b10);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_valid", bus.disp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        tick(20);

        // table: each vector captured at a random scan phase, hold length measured
        for (int i = 0; i < 8; i++) begin
            wait_ready();
            tick($urandom_range(0, 5));
            send(i);
            n = 0;
            while (bus.in_ready == 1'b0 && n < 10) begin n++; tick(1); end
            chk("hold_len", n, HOLD);
            tick(2 * RDIV + 1);
        end

        // a second in_valid during hold is dropped; same data at k+4 is taken
        wait_ready();
        send(1);
        send(5);
        tick(2);
        send(5);
        tick(2 * RDIV + 2);

        // capture on the digit-select wrap edge
        for (int j = 0; j < 2; j++) begin
            wait_ready();
            n = 0;
            while (m_cnt != RDIV - 1 && n < 8) begin tick(1); n++; end
            chk("align_wrap", m_cnt, RDIV - 1);
            send(j == 0 ? 6 : 3);
            tick(2 * RDIV + 1);
        end

        // reset mid-hold: outputs clear immediately, capture taken right after release
        wait_ready();
        send(1);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("hold_rst_seg", bus.seg, 7'h7F);
        chk("hold_rst_an", bus.an, 2'b10);
        chk("hold_rst_ready", bus.in_ready, 1'b1);
        chk("hold_rst_valid", bus.disp_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(7);
        chk("post_rst_valid", bus.disp_valid, 1'b1);
        tick(2 * RDIV + 2);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
